// File: rtl/iter_div_unit.sv
// Multi-cycle restoring divider for RV32M DIV/DIVU/REM/REMU, BITS_PER_CYCLE quotient bits per cycle.
// Optional macro DIV_EARLY_OUT_EN: finish at acceptance when |dividend| < |divisor|.
module iter_div_unit #(
    parameter int XLEN           = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic            start_i,
    input  logic            flush_i,
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] dividend_i,
    input  logic [XLEN-1:0] divisor_i,
    input  logic            ack_i,
    output logic            busy_o,
    output logic            valid_o,
    output logic [XLEN-1:0] result_o
);
    localparam int N  = XLEN / BITS_PER_CYCLE;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state_q;
    logic [XLEN-1:0] rem_q, rem_nx;
    logic [XLEN-1:0] dq_q, dq_nx;
    logic [XLEN-1:0] dvs_q;
    logic [CW-1:0]   cnt_q;
    logic            op_rem_q, q_neg_q, r_neg_q, fast_q;

    logic            is_signed, is_rem, div_zero, ovf, early, special, accept;
    logic [XLEN-1:0] abs_a, abs_b, sp_val, fin_q, fin_r;

    assign is_signed = (funct3_i == 3'b100) || (funct3_i == 3'b110);
    assign is_rem    = (funct3_i == 3'b110) || (funct3_i == 3'b111);
    assign abs_a     = (is_signed && dividend_i[XLEN-1]) ? -dividend_i : dividend_i;
    assign abs_b     = (is_signed && divisor_i[XLEN-1])  ? -divisor_i  : divisor_i;
    assign div_zero  = (divisor_i == '0);
    assign ovf       = is_signed && (dividend_i == INT_MIN) && (divisor_i == '1);
`ifdef DIV_EARLY_OUT_EN
    assign early     = !div_zero && (abs_a < abs_b);
`else
    assign early     = 1'b0;
`endif
    assign special   = div_zero || ovf || early;
    assign accept    = start_i && !flush_i &&
                       ((state_q == IDLE) || ((state_q == DONE) && ack_i));

    always_comb begin
        if (div_zero)  sp_val = is_rem ? dividend_i : '1;
        else if (ovf)  sp_val = is_rem ? '0 : dividend_i;
        else           sp_val = is_rem ? dividend_i : '0;
    end

    // Chained restoring steps on an XLEN+1-bit partial remainder, quotient bits shifted in MSB first.
    always_comb begin
        logic [XLEN:0] rw;
        rw    = {1'b0, rem_q};
        dq_nx = dq_q;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            // NOTE: blocking assignments here so each step sees the previous step's result in the same cycle.
            rw    = {rw[XLEN-1:0], dq_nx[XLEN-1]};
            dq_nx = {dq_nx[XLEN-2:0], 1'b0};
            if (rw >= {1'b0, dvs_q}) begin
                rw       = rw - {1'b0, dvs_q};
                dq_nx[0] = 1'b1;
            end
        end
        rem_nx = rw[XLEN-1:0];
    end

    assign fin_q = q_neg_q ? -dq_nx  : dq_nx;
    assign fin_r = r_neg_q ? -rem_nx : rem_nx;

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q  <= IDLE;
            busy_o   <= 1'b0;
            valid_o  <= 1'b0;
            result_o <= '0;
            rem_q    <= '0;
            dq_q     <= '0;
            dvs_q    <= '0;
            cnt_q    <= '0;
            op_rem_q <= 1'b0;
            q_neg_q  <= 1'b0;
            r_neg_q  <= 1'b0;
            fast_q   <= 1'b0;
        end else if (flush_i) begin
            state_q <= IDLE;
            busy_o  <= 1'b0;
            valid_o <= 1'b0;
            fast_q  <= 1'b0;
        end else if (accept) begin
            busy_o   <= 1'b1;
            op_rem_q <= is_rem;
            q_neg_q  <= is_signed && (dividend_i[XLEN-1] ^ divisor_i[XLEN-1]) && !div_zero;
            r_neg_q  <= is_signed && dividend_i[XLEN-1];
            dvs_q    <= abs_b;
            rem_q    <= '0;
            cnt_q    <= CW'(N - 1);
            if (special && (state_q == IDLE)) begin
                state_q  <= DONE;
                valid_o  <= 1'b1;
                result_o <= sp_val;
                fast_q   <= 1'b0;
            end else if (special) begin
                // Back-to-back special case: one RUN cycle so valid_o visibly drops.
                state_q <= RUN;
                valid_o <= 1'b0;
                dq_q    <= sp_val;
                fast_q  <= 1'b1;
            end else begin
                state_q <= RUN;
                valid_o <= 1'b0;
                dq_q    <= abs_a;
                fast_q  <= 1'b0;
            end
        end else begin
            case (state_q)
                RUN: begin
                    if (fast_q) begin
                        state_q  <= DONE;
                        valid_o  <= 1'b1;
                        result_o <= dq_q;
                        fast_q   <= 1'b0;
                    end else if (cnt_q == '0) begin
                        state_q  <= DONE;
                        valid_o  <= 1'b1;
                        result_o <= op_rem_q ? fin_r : fin_q;
                    end else begin
                        rem_q <= rem_nx;
                        dq_q  <= dq_nx;
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                DONE: begin
                    if (ack_i) begin
                        state_q <= IDLE;
                        valid_o <= 1'b0;
                        busy_o  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_iter_div_unit.sv
// Self-checking bench for iter_div_unit: BPC=1 and BPC=4 instances share stimulus,
// checked against an arithmetic reference model of RV32M division.
module tb_iter_div_unit;
    localparam int XLEN = 32;

    logic            clk_i = 1'b0;
    logic            reset_i = 1'b0;
    logic            start_i = 1'b0;
    logic            flush_i = 1'b0;
    logic            ack_i = 1'b0;
    logic [2:0]      funct3_i = '0;
    logic [XLEN-1:0] dividend_i = '0;
    logic [XLEN-1:0] divisor_i = '0;
    logic            busy1, valid1, busy4, valid4;
    logic [XLEN-1:0] res1, res4;

    int assertions = 0;
    int failures   = 0;

    always #5 clk_i = ~clk_i;

    iter_div_unit #(.XLEN(XLEN), .BITS_PER_CYCLE(1)) dut1 (
        .clk_i(clk_i), .reset_i(reset_i), .start_i(start_i), .flush_i(flush_i),
        .funct3_i(funct3_i), .dividend_i(dividend_i), .divisor_i(divisor_i), .ack_i(ack_i),
        .busy_o(busy1), .valid_o(valid1), .result_o(res1));

    iter_div_unit #(.XLEN(XLEN), .BITS_PER_CYCLE(4)) dut4 (
        .clk_i(clk_i), .reset_i(reset_i), .start_i(start_i), .flush_i(flush_i),
        .funct3_i(funct3_i), .dividend_i(dividend_i), .divisor_i(divisor_i), .ack_i(ack_i),
        .busy_o(busy4), .valid_o(valid4), .result_o(res4));

    function automatic bit f_signed(input logic [2:0] f);
        return (f == 3'b100) || (f == 3'b110);
    endfunction

    function automatic logic [31:0] mag(input bit sgn, input logic [31:0] x);
        return (sgn && x[31]) ? 32'd0 - x : x;
    endfunction

    function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        bit rem;
        int sa, sb;
        rem = (f == 3'b110) || (f == 3'b111);
        if (b == 32'd0) return rem ? a : 32'hFFFF_FFFF;
        if (f_signed(f)) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return rem ? 32'd0 : a;
            sa = a;
            sb = b;
            return rem ? 32'(sa % sb) : 32'(sa / sb);
        end
        return rem ? a % b : a / b;
    endfunction

    function automatic bit is_special(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        bit sp;
        sp = (b == 32'd0) || (f_signed(f) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
`ifdef DIV_EARLY_OUT_EN
        if (b != 32'd0 && mag(f_signed(f), a) < mag(f_signed(f), b)) sp = 1'b1;
`endif
        return sp;
    endfunction

    // Issue one operation and check result and valid latency on both instances.
    task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input bit b2b);
        logic [31:0] exp;
        int lat1, lat4, exp1, exp4;
        bit sp;
        exp = ref_model(f, a, b);
        sp  = is_special(f, a, b);
        exp1 = sp ? (b2b ? 2 : 1) : XLEN + 1;
        exp4 = sp ? (b2b ? 2 : 1) : XLEN / 4 + 1;
        if (!b2b && (valid1 || valid4)) begin
            ack_i = 1'b1;
            @(posedge clk_i); #1;
            ack_i = 1'b0;
            assertions++;
            if ({valid1, busy1, valid4, busy4} !== 4'b0000) begin
                failures++;
                $display("FAIL ack_to_idle: valid/busy x4 = %b expected 0000", {valid1, busy1, valid4, busy4});
            end
        end
        funct3_i = f; dividend_i = a; divisor_i = b; start_i = 1'b1; ack_i = b2b;
        lat1 = 0; lat4 = 0;
        for (int k = 1; k <= 40 && (lat1 == 0 || lat4 == 0); k++) begin
            @(posedge clk_i); #1;
            start_i = 1'b0; ack_i = 1'b0;
            if (valid1 && lat1 == 0) begin
                lat1 = k;
                assertions++;
                if (res1 !== exp) begin
                    failures++;
                    $display("FAIL result_bpc1 f=%b a=%h b=%h: got %h expected %h", f, a, b, res1, exp);
                end
            end
            if (valid4 && lat4 == 0) begin
                lat4 = k;
                assertions++;
                if (res4 !== exp) begin
                    failures++;
                    $display("FAIL result_bpc4 f=%b a=%h b=%h: got %h expected %h", f, a, b, res4, exp);
                end
            end
        end
        assertions++;
        if (lat1 != exp1) begin
            failures++;
            $display("FAIL latency_bpc1 f=%b a=%h b=%h b2b=%0d: got %0d expected %0d", f, a, b, b2b, lat1, exp1);
        end
        assertions++;
        if (lat4 != exp4) begin
            failures++;
            $display("FAIL latency_bpc4 f=%b a=%h b=%h b2b=%0d: got %0d expected %0d", f, a, b, b2b, lat4, exp4);
        end
    endtask

    task automatic test_reset;
        repeat (2) @(posedge clk_i);
        #1;
        assertions++;
        if ({busy1, valid1, res1, busy4, valid4, res4} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got %b/%b/%h %b/%b/%h expected all zero", busy1, valid1, res1, busy4, valid4, res4);
        end
        @(negedge clk_i) reset_i = 1'b1;
        @(posedge clk_i); #1;
        assertions++;
        if ({busy1, valid1, busy4, valid4} !== 4'b0000) begin
            failures++;
            $display("FAIL idle_after_reset: got %b expected 0000", {busy1, valid1, busy4, valid4});
        end
    endtask

    task automatic test_directed;
        run_op(3'b100, 32'd7, 32'hFFFF_FFFE, 1'b0);
        run_op(3'b110, 32'd7, 32'hFFFF_FFFE, 1'b0);
        run_op(3'b101, 32'd5, 32'd0, 1'b0);
        run_op(3'b111, 32'd5, 32'd0, 1'b0);
        run_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        run_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        run_op(3'b111, 32'd100, 32'd7, 1'b0);
        run_op(3'b101, 32'd3, 32'd10, 1'b0);
        run_op(3'b000, 32'd77, 32'd5, 1'b0);
    endtask

    task automatic test_hold;
        logic [31:0] exp;
        exp = ref_model(3'b101, 32'd100, 32'd7);
        run_op(3'b101, 32'd100, 32'd7, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk_i); #1;
            assertions++;
            if ({valid4, busy4, valid1, busy1} !== 4'b1111 || res4 !== exp || res1 !== exp) begin
                failures++;
                $display("FAIL hold_stable cycle %0d: v/b=%b res4=%h res1=%h expected 1111 %h", i,
                         {valid4, busy4, valid1, busy1}, res4, res1, exp);
            end
        end
    endtask

    task automatic test_back_to_back;
        run_op(3'b100, 32'd7, 32'hFFFF_FFFE, 1'b0);
        run_op(3'b110, 32'hFFFF_FFF9, 32'd2, 1'b1);
        run_op(3'b101, 32'd5, 32'd0, 1'b1);
        run_op(3'b100, 32'hFFFF_FF9C, 32'd7, 1'b1);
    endtask

    task automatic test_flush;
        bit seen;
        seen = 1'b0;
        if (valid1 || valid4) begin
            ack_i = 1'b1;
            @(posedge clk_i); #1;
            ack_i = 1'b0;
        end
        funct3_i = 3'b100; dividend_i = 32'd1000; divisor_i = 32'd7; start_i = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk_i); #1;
            start_i = 1'b0;
            if (valid1) seen = 1'b1;
        end
        flush_i = 1'b1; start_i = 1'b1; ack_i = 1'b1;
        @(posedge clk_i); #1;
        flush_i = 1'b0; start_i = 1'b0; ack_i = 1'b0;
        assertions++;
        if (seen) begin
            failures++;
            $display("FAIL flush_valid_early: valid1 rose before flush, expected no rise");
        end
        assertions++;
        if ({busy1, valid1, busy4, valid4} !== 4'b0000) begin
            failures++;
            $display("FAIL flush_idle: busy/valid = %b expected 0000", {busy1, valid1, busy4, valid4});
        end
        run_op(3'b101, 32'd9, 32'd3, 1'b0);
    endtask

    task automatic test_reset_mid_run;
        bit seen;
        seen = 1'b0;
        if (valid1 || valid4) begin
            ack_i = 1'b1;
            @(posedge clk_i); #1;
            ack_i = 1'b0;
        end
        funct3_i = 3'b101; dividend_i = 32'd12345; divisor_i = 32'd11; start_i = 1'b1;
        repeat (5) begin
            @(posedge clk_i); #1;
            start_i = 1'b0;
        end
        reset_i = 1'b0;
        #1;
        assertions++;
        if ({busy1, valid1, res1, busy4, valid4, res4} !== '0) begin
            failures++;
            $display("FAIL reset_mid_run: got %b/%b/%h %b/%b/%h expected all zero", busy1, valid1, res1, busy4, valid4, res4);
        end
        @(negedge clk_i) reset_i = 1'b1;
        repeat (40) begin
            @(posedge clk_i); #1;
            if (valid1 || valid4 || busy1 || busy4) seen = 1'b1;
        end
        assertions++;
        if (seen) begin
            failures++;
            $display("FAIL reset_no_result: activity after mid-run reset, expected none");
        end
    endtask

    task automatic test_random;
        logic [2:0]  f;
        logic [31:0] a, b;
        for (int i = 0; i < 30; i++) begin
            f = 3'($urandom_range(0, 7));
            a = $urandom;
            case ($urandom_range(0, 9))
                0: b = 32'd0;
                1: b = 32'hFFFF_FFFF;
                2: b = $urandom_range(1, 15);
                3: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                4: b = a + 32'd1;
                default: b = $urandom >> $urandom_range(0, 31);
            endcase
            run_op(f, a, b, 1'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_directed();
        test_hold();
        test_back_to_back();
        test_flush();
        test_reset_mid_run();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end
endmodule

// File: doc/iter_div_unit.md
Name: iter_div_unit

Overview:
Parametrised multi-cycle integer divider for the RV32M DIV/DIVU/REM/REMU path of the execute stage. It generalises the single-bit restoring divider in several ways: configurable width and bits-per-cycle, an explicit start/valid/ack handshake, hardware handling of divide-by-zero and signed-overflow, and flush abort. The execute stage stalls on busy_o and consumes result_o when valid_o is high.

Parameters:
XLEN, 32, operand and result width in bits (≥8, even).
BITS_PER_CYCLE, 1, quotient bits retired per RUN cycle; legal values 1, 2, 4; must divide XLEN.

Ports:
clk_i  in  1  clock, all state on rising edge
reset_i  in  1  asynchronous, active-low reset
start_i  in  1  request a division; sampled only when acceptance is allowed
flush_i  in  1  abort current operation (pipeline flush)
funct3_i  in  3  op select: 100 DIV, 101 DIVU, 110 REM, 111 REMU; others treated as DIVU
dividend_i  in  XLEN  rs1 value, sampled on acceptance
divisor_i  in  XLEN  rs2 value, sampled on acceptance
ack_i  in  1  consumer takes result; meaningful only while valid_o=1
busy_o  out  1  high in RUN and DONE; also high while valid_o is held
valid_o  out  1  result_o holds a final result
result_o  out  XLEN  quotient or remainder, sign-corrected

Behaviour:
- Reset (reset_i=0, async): state=IDLE; busy_o=0, valid_o=0, result_o=0; internal registers cleared.
- States: IDLE, RUN, DONE.
- Acceptance: start_i=1 and (state=IDLE, or state=DONE with ack_i=1 in the same cycle) and flush_i=0. A start_i at any other time is ignored; no queueing.
- On acceptance at cycle T, latch: op, |dividend|, |divisor| (absolute values only for signed ops), quotient sign = signed & sign differ & divisor≠0, remainder sign = signed & dividend[XLEN-1].
- Special cases at acceptance go straight to DONE, with valid_o=1 from T+1:
  - divisor=0: quotient = all ones; remainder = dividend unchanged.
  - Signed overflow (DIV/REM, dividend = 1<<(XLEN-1), divisor = all ones): quotient = dividend; remainder = 0.
- Normal path: IDLE→RUN at T+1. RUN lasts N = XLEN/BITS_PER_CYCLE cycles.
  - Each RUN cycle performs BITS_PER_CYCLE chained restoring shift-subtract steps on an XLEN+1-bit partial remainder.
  - Each cycle shifts BITS_PER_CYCLE quotient bits in, MSB first.
  - An iteration counter counts N-1 down to 0. At count 0, go to DONE.
  - result_o is registered with sign correction (two's-complement negate where the sign flag is set) and valid_o=1 from T+N+1.
- DONE: valid_o and result_o are held stable until ack_i=1.
  - ack_i=1 without a new start: go to IDLE; valid_o=0 the next cycle; result_o keeps its last value.
  - ack_i=1 with start_i=1: back-to-back acceptance; valid_o drops for at least one cycle.
- flush_i=1 in any state: next state IDLE, valid_o=0, busy_o=0 next cycle; the partial result is discarded.
  - flush_i has priority over start_i and ack_i in the same cycle.
- Reset asserted mid-operation: immediate return to reset values; no result is produced.
- Arithmetic: all negations are modulo 2^XLEN. The quotient satisfies dividend = q*divisor + r, with |r| < |divisor| and sign(r) = sign(dividend), per the RISC-V M spec.

Optional Feature:
Macro DIV_EARLY_OUT_EN.
- Defined: at acceptance, if |dividend| < |divisor| (divisor≠0), skip RUN and go to DONE with valid_o at T+1. Result: quotient 0; remainder = dividend (original signed value).
- Not defined: such operands take the full N-cycle RUN path and give identical results.

Test Plan:
- XLEN=32, BPC=1, DIV 7 / 0xFFFFFFFE at T -> valid_o rises at T+33, result_o=0xFFFFFFFD; repeat with REM -> 0x00000001.
- DIVU 5 / 0 -> valid_o at T+1, result 0xFFFFFFFF; REMU 5 / 0 -> 5; DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000, REM -> 0, both valid at T+1.
- BPC=4: DIVU 100 / 7 -> valid at T+9, result 14; REMU -> 2; hold ack_i=0 for 5 cycles -> result_o stable, busy_o=1 throughout.
- Start at T, flush_i=1 at T+10 -> busy_o=0 at T+11, valid_o never rises; new DIVU 9/3 accepted at T+11 -> 3 at T+44 (BPC=1).
- Back-to-back: in DONE, ack_i=1 and start_i=1 (REM 0xFFFFFFF9 / 2) -> new op accepted; result 0xFFFFFFFF; reset_i pulsed low mid-RUN -> all outputs 0 immediately.
- DIV_EARLY_OUT_EN defined: DIVU 3 / 10 -> valid at T+1, result 0; undefined -> valid at T+33, result 0.
